// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller and the
// execute-stage forwarding muxes in the datapath.
package hazard_pkg;

    localparam int FWD_RF     = 0;
    // Widest register address any configuration may use; narrower rd values are zero-extended.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  is_load;
        logic [REG_AW_MAX-1:0] rd;
    } stage_entry_t;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority encoder for one source operand: finds the youngest in-flight
// producer of that register and reports whether its value is usable yet.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = sel_width(NUM_STAGES)
) (
    input  stage_entry_t [NUM_STAGES-1:0] stages,
    input  logic [REG_AW-1:0]             rs,
    input  logic                          rs_used,
    output logic                          hit,
    output logic [SEL_W-1:0]              idx,
    output logic                          ready
);

    logic src_live;

    assign src_live = rs_used && (rs != '0);

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        hit   = 1'b0;
        idx   = SEL_W'(FWD_RF);
        ready = 1'b1;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (src_live && stages[k].valid && stages[k].we &&
                stages[k].rd == REG_AW_MAX'(rs)) begin
                hit   = 1'b1;
                idx   = SEL_W'(k + 1);
                ready = !stages[k].is_load || ((k + 1) >= LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Stage-generic hazard and forwarding controller: tracks in-flight writers,
// produces registered bypass selects, a load-use hold and a redirect kill.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int SEL_W       = sel_width(NUM_STAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ext_stall,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      redirect,
    output logic                      hold_id,
    output logic                      kill_id,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [NUM_STAGES-1:0]     pipe_valid,
    output logic                      wb_we
);

    localparam int KW = sel_width(FLUSH_DEPTH);

    stage_entry_t [NUM_STAGES-1:0] stage_q;
    logic [KW-1:0]                 kill_cnt;
    logic [NUM_SRC-1:0]            hit;
    logic [NUM_SRC-1:0]            ready;
    logic [SEL_W-1:0]              idx [NUM_SRC];
    logic                          issue;
    stage_entry_t                  new_entry;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_match #(
            .NUM_STAGES(NUM_STAGES),
            .REG_AW    (REG_AW),
            .LOAD_LAT  (LOAD_LAT),
            .SEL_W     (SEL_W)
        ) u_match (
            .stages (stage_q),
            .rs     (id_rs[i*REG_AW +: REG_AW]),
            .rs_used(id_rs_used[i]),
            .hit    (hit[i]),
            .idx    (idx[i]),
            .ready  (ready[i])
        );
    end

    assign kill_id = redirect || (kill_cnt != '0);
    assign hold_id = id_valid && !kill_id && |(hit & ~ready);
    assign issue   = id_valid && !kill_id && !hold_id;

    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid   = 1'b1;
            new_entry.we      = id_we;
            new_entry.is_load = id_is_load;
            new_entry.rd      = REG_AW_MAX'(id_rd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q  <= '0;
            fwd_sel  <= '0;
            kill_cnt <= '0;
        end else if (!ext_stall) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                stage_q[k] <= stage_q[k-1];
            end
            stage_q[0] <= new_entry;
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_sel[i*SEL_W +: SEL_W] <= (issue && hit[i]) ? idx[i] : SEL_W'(FWD_RF);
            end
            if (redirect) begin
                kill_cnt <= KW'(FLUSH_DEPTH - 1);
            end else if (kill_cnt != '0) begin
                kill_cnt <= kill_cnt - KW'(1);
            end
        end
    end

    always_comb begin
        pipe_valid = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            pipe_valid[k] = stage_q[k].valid;
        end
    end

    // The writeback write is suppressed while frozen so a stalled retire is not written twice.
    assign wb_we = stage_q[NUM_STAGES-1].valid && stage_q[NUM_STAGES-1].we && !ext_stall;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed scenarios then random traffic
// checked against an in-order pipeline occupancy model.
module tb_hazard_fwd_unit;

    localparam int N        = 3;
    localparam int NS       = 2;
    localparam int AW       = 5;
    localparam int LOAD_LAT = 2;
    localparam int FD       = 2;
    localparam int SW       = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ext_stall = 1'b0;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rd = '0;
    logic            id_we = 1'b0;
    logic            id_is_load = 1'b0;
    logic [NS*AW-1:0] id_rs = '0;
    logic [NS-1:0]   id_rs_used = '0;
    logic            redirect = 1'b0;
    logic            hold_id;
    logic            kill_id;
    logic [NS*SW-1:0] fwd_sel;
    logic [N-1:0]    pipe_valid;
    logic            wb_we;

    hazard_fwd_unit #(
        .NUM_STAGES (N),
        .NUM_SRC    (NS),
        .REG_AW     (AW),
        .LOAD_LAT   (LOAD_LAT),
        .FLUSH_DEPTH(FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_stall (ext_stall),
        .id_valid  (id_valid),
        .id_rd     (id_rd),
        .id_we     (id_we),
        .id_is_load(id_is_load),
        .id_rs     (id_rs),
        .id_rs_used(id_rs_used),
        .redirect  (redirect),
        .hold_id   (hold_id),
        .kill_id   (kill_id),
        .fwd_sel   (fwd_sel),
        .pipe_valid(pipe_valid),
        .wb_we     (wb_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } ent_t;

    typedef struct packed {
        logic           hold;
        logic           kill;
        logic           wb;
        logic [N-1:0]   pv;
        logic [NS*SW-1:0] fwd;
    } exp_t;

    ent_t pipe[$];
    int   m_kill;
    int   m_fwd[NS];
    exp_t sb[$];
    bit   last_hold;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k < N; k++) pipe.push_back('{0, 0, 0, 0});
        m_kill = 0;
        for (int i = 0; i < NS; i++) m_fwd[i] = 0;
    endtask

    // One decode cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input bit rst_v, input bit stall, input bit valid, input bit we,
                        input bit ld, input int rd, input int rs0, input int rs1,
                        input bit [1:0] used, input bit redir);
        exp_t e;
        int   win [NS];
        bit   any_nr;
        bit   issue;
        int   rsx;
        reset      = rst_v;
        ext_stall  = stall;
        id_valid   = valid;
        id_we      = we;
        id_is_load = ld;
        id_rd      = AW'(rd);
        id_rs      = {AW'(rs1), AW'(rs0)};
        id_rs_used = used;
        redirect   = redir;
        if (!rst_v) model_reset();

        e.kill = redir || (m_kill != 0);
        any_nr = 1'b0;
        for (int i = 0; i < NS; i++) begin
            rsx    = (i == 0) ? rs0 : rs1;
            win[i] = 0;
            if (used[i] && rsx != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (pipe[k].v && pipe[k].we && pipe[k].rd == rsx) begin
                        win[i] = k + 1;
                        if (pipe[k].ld && (k + 1) < LOAD_LAT) any_nr = 1'b1;
                        break;
                    end
                end
            end
        end
        e.hold = valid && !e.kill && any_nr;
        e.wb   = pipe[N-1].v && pipe[N-1].we && !stall;
        for (int k = 0; k < N; k++) e.pv[k] = pipe[k].v;
        for (int i = 0; i < NS; i++) e.fwd[i*SW +: SW] = SW'(m_fwd[i]);
        sb.push_back(e);
        last_hold = e.hold;

        if (rst_v && !stall) begin
            issue = valid && !e.kill && !e.hold;
            for (int i = 0; i < NS; i++) m_fwd[i] = issue ? win[i] : 0;
            if (issue) pipe.push_front('{1, we, ld, rd});
            else       pipe.push_front('{0, 0, 0, 0});
            void'(pipe.pop_back());
            if (redir)           m_kill = FD - 1;
            else if (m_kill > 0) m_kill = m_kill - 1;
        end
    endtask

    task automatic go(input bit rst_v, input bit stall, input bit valid, input bit we,
                      input bit ld, input int rd, input int rs0, input int rs1,
                      input bit [1:0] used, input bit redir);
        @(posedge clk);
        #1;
        step(rst_v, stall, valid, we, ld, rd, rs0, rs1, used, redir);
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hold_id",    int'(hold_id),    int'(e.hold));
                chk("kill_id",    int'(kill_id),    int'(e.kill));
                chk("wb_we",      int'(wb_we),      int'(e.wb));
                chk("pipe_valid", int'(pipe_valid), int'(e.pv));
                chk("fwd_sel",    int'(fwd_sel),    int'(e.fwd));
            end
        end
    end

    initial begin : driver
        bit   stall, valid, we, ld, redir, prev_stall, prev_redir;
        int   rd, rs0, rs1;
        bit [1:0] used;
        int   guard;
        model_reset();
        last_hold = 1'b0;

        go(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        go(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // back-to-back ALU forward
        go(1, 0, 1, 1, 0, 5, 1, 2, 2'b00, 0);
        go(1, 0, 1, 1, 0, 6, 5, 0, 2'b01, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // load-use: one hold then fwd from stage 2 on both sources
        go(1, 0, 1, 1, 1, 7, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 8, 7, 7, 2'b11, 0);
        go(1, 0, 1, 1, 0, 8, 7, 7, 2'b11, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // priority: youngest writer of x3 wins; x0 never matches
        go(1, 0, 1, 1, 0, 3, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 3, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 9, 3, 0, 2'b01, 0);
        go(1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 4, 0, 0, 2'b11, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // redirect beats a concurrent load-use
        go(1, 0, 1, 1, 1, 9, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 10, 9, 0, 2'b01, 1);
        go(1, 0, 1, 1, 0, 11, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 12, 0, 0, 2'b00, 0);
        // stall mid-flush
        go(1, 0, 1, 1, 0, 13, 0, 0, 2'b00, 1);
        go(1, 1, 1, 1, 0, 14, 0, 0, 2'b00, 0);
        go(1, 1, 1, 1, 0, 14, 0, 0, 2'b00, 0);
        go(1, 1, 1, 1, 0, 14, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 14, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 15, 0, 0, 2'b00, 0);
        // async reset during a hold
        go(1, 0, 1, 1, 1, 4, 0, 0, 2'b00, 0);
        go(1, 0, 1, 1, 0, 5, 4, 0, 2'b01, 0);
        go(0, 0, 1, 1, 0, 5, 4, 0, 2'b01, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

        prev_stall = 0; prev_redir = 0;
        valid = 0; we = 0; ld = 0; rd = 0; rs0 = 0; rs1 = 0; used = 0;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 9) == 0);
            redir = (prev_stall && prev_redir) ? 1'b1 : ($urandom_range(0, 11) == 0);
            if (!last_hold) begin
                valid = ($urandom_range(0, 6) != 0);
                we    = ($urandom_range(0, 4) != 0);
                ld    = ($urandom_range(0, 2) == 0);
                rd    = $urandom_range(0, 3);
                rs0   = $urandom_range(0, 3);
                rs1   = $urandom_range(0, 3);
                used  = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0) go(0, 0, valid, we, ld, rd, rs0, rs1, used, 0);
            else                             go(1, stall, valid, we, ld, rd, rs0, rs1, used, redir);
            prev_stall = stall;
            prev_redir = redir;
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for an in-order RISC-V pipeline with NUM_STAGES producer stages after decode.
- Tracks in-flight destination registers in a valid/rd/we/is_load shift register.
- Generates registered per-source forwarding selects for the execute stage, a load-use hold for decode, and a multi-cycle redirect kill.
- Sits beside the decoder and replaces fixed two-way bypass logic with stage-generic forwarding.

Parameters:
- NUM_STAGES, 3: producer stages tracked (stage 1 = execute, stage NUM_STAGES = writeback).
- NUM_SRC, 2: source operands per instruction.
- REG_AW, 5: register address width.
- LOAD_LAT, 2: first stage index whose output holds load data.
- FLUSH_DEPTH, 1: number of consecutive decode slots killed per redirect (≥1).
- SEL_W, $clog2(NUM_STAGES+1): forwarding select width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ext_stall  in  1  global freeze (cache miss); all state holds.
- id_valid  in  1  decode slot holds a real instruction.
- id_rd  in  REG_AW  decode destination register.
- id_we  in  1  decode instruction writes the regfile.
- id_is_load  in  1  decode instruction is a load.
- id_rs  in  NUM_SRC*REG_AW  decode source registers, source i at [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  source i is actually read.
- redirect  in  1  taken branch/jump resolved in stage 1.
- hold_id  out  1  load-use hold; decode and PC must not advance (combinational).
- kill_id  out  1  decode slot is squashed (combinational).
- fwd_sel  out  NUM_SRC*SEL_W  registered select per source for stage 1.
- pipe_valid  out  NUM_STAGES  per-stage live-instruction flag.
- wb_we  out  1  pipe_valid[N] & we[N], gated by ~ext_stall.

Behaviour:
- Reset (async, reset=0): all stage valid/we/is_load = 0, rd = 0, fwd_sel = 0, kill_cnt = 0. Outputs: hold_id = 0, kill_id = 0, wb_we = 0.
- Match, per source i: stage k matches if id_rs_used[i], id_rs[i] != 0, valid[k], we[k], and rd[k] == id_rs[i]. The smallest matching k (youngest producer) wins.
- Readiness: the winner is ready if ~is_load[k] or k ≥ LOAD_LAT. Otherwise the source is not ready.
- hold_id = id_valid & ~kill_id & (any source not ready).
- kill_id = redirect | (kill_cnt != 0).
- Redirect wins over a hold: hold_id is forced 0 when kill_id = 1.
- fwd_sel encoding (registered, so it is applied while the consumer sits in stage 1):
  - 0 = regfile.
  - k = value that was in stage k when the consumer was in decode. It is now in stage k+1's register.
  - k = NUM_STAGES selects the datapath's one-deep retired-value register.
- On each rising edge with ext_stall = 0:
  - Stages 2..N take stages 1..N-1.
  - Stage 1 takes the decode entry with valid = id_valid & ~kill_id & ~hold_id. Otherwise it takes a bubble (valid = 0, we = 0).
  - fwd_sel loads the winner index, or 0 if there is no match, the slot is a bubble, or the slot is killed.
  - kill_cnt loads FLUSH_DEPTH-1 on redirect; otherwise it decrements if nonzero.
- ext_stall = 1: every register holds, including kill_cnt. redirect is ignored; the datapath keeps it asserted until the stall clears. hold_id and kill_id remain combinationally valid.
- Latency: a hold lasts (LOAD_LAT - k) cycles with no ext_stall. For the defaults (k = 1, LOAD_LAT = 2) this is exactly 1 bubble.
- A redirect with FLUSH_DEPTH = 1 kills only the current decode slot.
- A reset mid-hold or mid-flush returns to idle immediately. No pending kill survives reset.
- Registers x0 writes never match, so they never forward or hold.

Decomposition:
- Shared package (hazard_pkg) holds:
  - FWD_RF = 0 encoding constant.
  - a stage-entry struct {valid, we, is_load, rd}.
  - a clog2-based select-width helper, which is also used by datapath muxes.
- One sub-module, hazard_match:
  - per-source priority encoder over NUM_STAGES entries.
  - outputs {hit, idx, ready}.
  - instantiated NUM_SRC times via generate.

Test Plan:
- Back-to-back ALU, defaults: add x5 (cycle 0), then sub uses x5 in cycle 1. Expect hold_id = 0, fwd_sel[0] = 1 in cycle 2, pipe_valid = 3'b011 at cycle 2.
- Load-use: lw x7, then add x8,x7,x7 next cycle. Expect hold_id = 1 for exactly one cycle and a bubble in stage 1. Then fwd_sel[0] = fwd_sel[1] = 2.
- Priority: x3 written in stages 1 and 2. Decode reads x3; expect fwd_sel = 1 (youngest). With rs = x0 instead, expect fwd_sel = 0.
- Redirect with FLUSH_DEPTH = 2: redirect pulse in cycle 4. Expect kill_id = 1 in cycles 4 and 5, stage-1 valid = 0 in cycles 5 and 6. A concurrent load-use gives hold_id = 0.
- ext_stall held 3 cycles mid-flush (kill_cnt = 1): counter, stages, and fwd_sel are unchanged and wb_we = 0. After release, kill_id = 1 for exactly one more cycle.
- Assert reset = 0 asynchronously during a hold. All outputs are 0 before the next edge; after release, pipe_valid = 0.
